// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pattern_gen
//  Brief    : VGA raster timing plus four selectable test patterns for a
//             2-bit-per-channel resistor DAC.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int BAR_W    = 80,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BW      = $clog2(BAR_W + 1);

    localparam logic [HW-1:0] c_H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] c_V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [BW-1:0] c_SUB_LAST = BW'(BAR_W - 1);

    // Decode boundaries kept at 32 bits so a zero porch cannot wrap them.
    localparam logic [31:0] c_H_ACT    = 32'(H_ACTIVE);
    localparam logic [31:0] c_HS_BEG   = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] c_HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] c_V_ACT    = 32'(V_ACTIVE);
    localparam logic [31:0] c_VS_BEG   = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] c_VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic [2:0]    r_bar;
    logic [BW-1:0] r_bar_sub;
    logic [1:0]    r_mode_q;

    logic [31:0]   w_hc;
    logic [31:0]   w_vc;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_origin;
    logic          w_vis;
    logic          w_hs;
    logic          w_vs;
    logic [1:0]    w_mode;
    logic [1:0]    w_r;
    logic [1:0]    w_g;
    logic [1:0]    w_b;

    assign w_hc     = 32'(r_hcnt);
    assign w_vc     = 32'(r_vcnt);
    assign w_h_wrap = (r_hcnt == c_H_LAST);
    assign w_v_wrap = (r_vcnt == c_V_LAST);
    assign w_origin = (r_hcnt == '0) && (r_vcnt == '0);
    assign w_vis    = (w_hc < c_H_ACT) && (w_vc < c_V_ACT);
    assign w_hs     = (w_hc >= c_HS_BEG) && (w_hc < c_HS_END);
    assign w_vs     = (w_vc >= c_VS_BEG) && (w_vc < c_VS_END);

    // Pixel (0,0) already uses the mode being latched on that same cycle.
    assign w_mode   = w_origin ? mode : r_mode_q;

    always_comb begin
        w_r = 2'd0;
        w_g = 2'd0;
        w_b = 2'd0;
        unique case (w_mode)
            2'd0: begin
                w_r = r_bar[2] ? 2'd3 : r_bar[1:0];
                w_g = w_r;
                w_b = w_r;
            end
            2'd1: begin
                w_r = {r_bar[2], r_bar[2]};
                w_g = {r_bar[1], r_bar[1]};
                w_b = {r_bar[0], r_bar[0]};
            end
            2'd2: begin
                w_r = (w_hc[3] ^ w_vc[3]) ? 2'd3 : 2'd0;
                w_g = w_r;
                w_b = w_r;
            end
            default: begin
                w_r = w_vc[1:0];
                w_g = w_r;
                w_b = w_r;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_bar       <= '0;
            r_bar_sub   <= '0;
            r_mode_q    <= 2'd0;
            r           <= 2'd0;
            g           <= 2'd0;
            b           <= 2'd0;
            active      <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
        end else begin
            r_hcnt <= w_h_wrap ? '0 : r_hcnt + 1'b1;
            if (w_h_wrap) begin
                r_vcnt <= w_v_wrap ? '0 : r_vcnt + 1'b1;
            end

            // Bar index tracks hcnt / BAR_W without a divider, saturating at 7.
            if (w_h_wrap) begin
                r_bar     <= '0;
                r_bar_sub <= '0;
            end else if (r_bar_sub == c_SUB_LAST) begin
                r_bar_sub <= '0;
                if (r_bar != 3'd7) begin
                    r_bar <= r_bar + 3'd1;
                end
            end else begin
                r_bar_sub <= r_bar_sub + 1'b1;
            end

            if (w_origin) begin
                r_mode_q <= mode;
            end

            r           <= w_vis ? w_r : 2'd0;
            g           <= w_vis ? w_g : 2'd0;
            b           <= w_vis ? w_b : 2'd0;
            active      <= w_vis;
            frame_start <= w_origin;
            hsync       <= w_hs ? SYNC_POL : ~SYNC_POL;
            vsync       <= w_vs ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_pattern_gen
//  Brief    : Self-checking bench for vga_pattern_gen against a frame-position
//             reference model, directed phases followed by random mode/reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_pattern_gen;

    localparam int H_ACTIVE = 8;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 3;
    localparam int V_ACTIVE = 4;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int BAR_W    = 2;
    localparam bit SYNC_POL = 1'b0;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [1:0] r, g, b;
    logic       hsync, vsync, active, frame_start;

    int n_vec = 0;
    int n_bad = 0;

    // Model state: linear position within the frame and latched mode.
    int p  = 0;
    int mq = 0;
    int e_r, e_g, e_b, e_hs, e_vs, e_act, e_fs;

    always #5 clk = ~clk;

    vga_pattern_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .BAR_W(BAR_W), .SYNC_POL(SYNC_POL)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .r          (r),
        .g          (g),
        .b          (b),
        .hsync      (hsync),
        .vsync      (vsync),
        .active     (active),
        .frame_start(frame_start)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (pos %0d, t=%0t)", tag, got, exp, p, $time);
        end
    endtask

    task automatic model(input logic rst_v, input logic [1:0] mode_v);
        int h, v, bar, lvl;
        if (rst_v) begin
            p = 0;
            e_r = 0; e_g = 0; e_b = 0;
            e_act = 0; e_fs = 0;
            e_hs = int'(!SYNC_POL); e_vs = int'(!SYNC_POL);
        end else begin
            h = p % H_TOTAL;
            v = p / H_TOTAL;
            if (p == 0) mq = int'(mode_v);
            bar = h / BAR_W;
            if (bar > 7) bar = 7;
            e_act = (h < H_ACTIVE && v < V_ACTIVE) ? 1 : 0;
            e_fs  = (p == 0) ? 1 : 0;
            e_hs  = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? int'(SYNC_POL) : int'(!SYNC_POL);
            e_vs  = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? int'(SYNC_POL) : int'(!SYNC_POL);
            case (mq)
                0: begin lvl = (bar > 3) ? 3 : bar; e_r = lvl; e_g = lvl; e_b = lvl; end
                1: begin e_r = ((bar / 4) % 2) * 3; e_g = ((bar / 2) % 2) * 3; e_b = (bar % 2) * 3; end
                2: begin lvl = (((h / 8) % 2) != ((v / 8) % 2)) ? 3 : 0; e_r = lvl; e_g = lvl; e_b = lvl; end
                default: begin e_r = v % 4; e_g = v % 4; e_b = v % 4; end
            endcase
            if (e_act == 0) begin e_r = 0; e_g = 0; e_b = 0; end
            p = (p + 1) % FRAME;
        end
    endtask

    // One clock: inputs are held from the preceding falling edge, outputs
    // are sampled 1 time unit after the rising edge.
    task automatic step(input logic rst_v, input logic [1:0] mode_v);
        rst  = rst_v;
        mode = mode_v;
        @(posedge clk);
        model(rst_v, mode_v);
        #1;
        chk("r",      8'(r),           8'(e_r));
        chk("g",      8'(g),           8'(e_g));
        chk("b",      8'(b),           8'(e_b));
        chk("hsync",  8'(hsync),       8'(e_hs));
        chk("vsync",  8'(vsync),       8'(e_vs));
        chk("active", 8'(active),      8'(e_act));
        chk("fstart", 8'(frame_start), 8'(e_fs));
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] m;
        rst  = 1'b1;
        mode = 2'd0;
        for (int i = 0; i < 3; i++) step(1'b1, 2'd0);
        for (int i = 0; i < FRAME; i++) step(1'b0, 2'd0);   // gray bars
        for (int i = 0; i < FRAME; i++) step(1'b0, 2'd1);   // colour bars
        for (int i = 0; i < 40; i++) step(1'b0, 2'd0);      // switch mid line 2
        for (int i = 0; i < 2 * FRAME - 40; i++) step(1'b0, 2'd1);
        for (int i = 0; i < FRAME; i++) step(1'b0, 2'd3);   // vertical ramp
        for (int i = 0; i < FRAME; i++) step(1'b0, 2'd2);   // checkerboard
        for (int i = 0; i < 11; i++) step(1'b0, 2'd2);      // reach hcnt=11
        step(1'b1, 2'd2);
        step(1'b1, 2'd0);
        for (int i = 0; i < FRAME + 5; i++) step(1'b0, 2'd0);

        m = 2'($urandom_range(0, 3));
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) m = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0, m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Video source feeding the 2-bit-per-channel resistor DAC on r/g/b, plus horizontal and vertical sync.
- Generates VGA-style raster timing with two counters.
- Emits one of four test patterns inside the active area and forces black during blanking.
- Used for bring-up of the DAC and monitor path; replaces free-running intensity stepping with proper video timing.

Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, pixels
- H_SYNC, 96: hsync pulse width, pixels
- H_BP, 48: horizontal back porch, pixels
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch, lines
- V_SYNC, 2: vsync pulse width, lines
- V_BP, 33: vertical back porch, lines
- BAR_W, 80: width of one pattern bar, pixels (must be ≥1)
- SYNC_POL, 0: asserted level of hsync/vsync (0 = negative sync)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- mode  in  2  pattern select, sampled once per frame
- r  out  2  red DAC code
- g  out  2  green DAC code
- b  out  2  blue DAC code
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- active  out  1  high while the pixel is in the visible area
- frame_start  out  1  one-cycle pulse marking pixel (0,0)

Behaviour:
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
  - Counter widths are $clog2 of each total; no truncation at defaults.
- Counters:
  - hcnt runs 0..H_TOTAL-1 and wraps to 0.
  - vcnt increments only on the cycle hcnt wraps, and itself wraps V_TOTAL-1 → 0.
  - Simultaneous wrap of both counters gives hcnt=0, vcnt=0 on the next cycle.
- Decode, all from the current (hcnt, vcnt):
  - vis = hcnt<H_ACTIVE && vcnt<V_ACTIVE
  - hs = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs = vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
- Output registers:
  - All outputs are registered, with exactly one cycle of latency from the counter value.
  - The output at cycle n+1 describes the pixel (hcnt, vcnt) at cycle n.
  - hsync = SYNC_POL when hs, else ~SYNC_POL. vsync follows the same rule using vs.
  - frame_start = 1 for the pixel hcnt=0, vcnt=0 only.
- Mode latch: mode_q captures mode on the cycle the counters are at (0,0). A mode change mid-frame takes effect at the next frame. No tearing.
- Patterns (apply when vis; otherwise r=g=b=0):
  - bar = hcnt / BAR_W, saturated at 7.
  - mode_q 0, gray bars: r=g=b=min(bar,3).
  - mode_q 1, colour bars: r={bar[2],bar[2]}, g={bar[1],bar[1]}, b={bar[0],bar[0]}.
  - mode_q 2, checkerboard: r=g=b = (hcnt[3]^vcnt[3]) ? 3 : 0.
  - mode_q 3, vertical ramp: r=g=b=vcnt[1:0].
  - Implement the division by a bar counter (reset at hcnt=0, step every BAR_W pixels), not a divider.
- Reset:
  - hcnt=0, vcnt=0, bar counter 0, mode_q=0.
  - r=g=b=0, active=0, frame_start=0, hsync=vsync=~SYNC_POL.
  - Reset asserted mid-line or mid-frame aborts immediately; sync is deasserted on the next edge.
  - The first cycle after rst falls has counters at (0,0). The cycle after that shows frame_start=1, active=1, and mode_q = mode sampled at that (0,0).
- No other state; the block free-runs with no backpressure.

Test Plan:
Bench parameters: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=16); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); BAR_W=2; SYNC_POL=0.
- Reset for 3 cycles, release, mode=0 → frame_start=1 exactly 1 cycle after release, then every 128 cycles. hsync low for 3 cycles starting at line offset 10 of each 16. vsync low for lines 5–6 (32 cycles).
- mode=0, line 0 → r=g=b sequence 0,0,1,1,2,2,3,3 then 0 for 8 blanking cycles. active high for 8 of 16 cycles.
- mode=1 → bars 0..3 give (r,g,b) = (0,0,0), (0,0,3), (0,3,0), (0,3,3) at 2 pixels each. Lines 4–7 are all black with active=0.
- mode changed 0→1 during line 2 → remainder of frame stays gray. The frame following the next frame_start shows colour bars.
- mode=3 → each active line v outputs r=g=b=v for v=0..3 across all 8 pixels.
- rst asserted while hcnt=11 (hsync low) → next cycle hsync=1, rgb=0, active=0. After release, timing restarts at (0,0) with frame_start.
